rgb_led_arbiter: RTL and testbench
==================================

Name: rgb_led_arbiter

Overview:
Shares the single on-die RGB LED driver between NUM_REQ requesters, e.g. status, heartbeat and error logic. Each requester asks for an RGB colour given as three duty values.
A fixed-priority arbiter with a minimum-ownership time picks one owner. The block generates glitch-free PWM for the owner's colour, and pwm_red/green/blue drive the RGB driver primitive's PWM inputs directly.
Grant and colour change only at PWM period boundaries, so the LED never shows a partial period.

Parameters:
NUM_REQ, 2, number of requesters; index 0 has the highest priority.
PWM_BITS, 8, PWM counter and duty width.
PRESCALE, 4, clock cycles per PWM counter tick; must be >= 1.
MIN_HOLD, 16, PWM periods an owner keeps the LED before a higher-priority requester may preempt it; must be >= 1.

Ports:
clk  in  1  single clock, e.g. the internal 48 MHz oscillator
rst  in  1  reset, asynchronous, active-high
req  in  NUM_REQ  level request per requester
duty_r  in  NUM_REQ*PWM_BITS  red duty; requester i uses slice [i*PWM_BITS +: PWM_BITS]
duty_g  in  NUM_REQ*PWM_BITS  green duty, same packing
duty_b  in  NUM_REQ*PWM_BITS  blue duty, same packing
grant  out  NUM_REQ  one-hot current owner, or all zero
busy  out  1  high while any requester owns the LED
period_start  out  1  one-cycle pulse at each PWM period boundary
pwm_red  out  1  red PWM
pwm_green  out  1  green PWM
pwm_blue  out  1  blue PWM

Behaviour:
- Reset is asynchronous. All outputs are 0; the prescaler, PWM counter, hold counter and latched duties are 0; the FSM is in IDLE.
- Prescaler counts 0..PRESCALE-1. tick is asserted when the prescaler equals PRESCALE-1.
- PWM counter increments on tick and wraps from 2^PWM_BITS-1 to 0.
- Boundary is defined as tick AND pwm counter at its maximum value. period_start is registered and pulses in the cycle after a boundary, aligned with the counter reading 0.
- Period length is PRESCALE*2^PWM_BITS clocks (1024 clocks with defaults).
- Each pwm_x is a registered (counter < active_duty_x), so it lags the counter by 1 cycle.
  - duty 0 gives a constant 0.
  - duty 255 gives high for 255 of 256 ticks.
- Active duties are latched only at a boundary: from the new or continuing owner's slice, or all zero if there is no owner. Duty input changes mid-period are ignored.
- Arbitration is evaluated only at a boundary. The highest-priority candidate is the lowest set index of req.
- FSM states: IDLE, LOCKED, OPEN. All transitions below happen only at a boundary.
  - IDLE: if any req, grant the highest-priority one, clear the hold counter and go to LOCKED. Otherwise stay in IDLE with grant=0.
  - LOCKED: the hold counter increments once per boundary and saturates at MIN_HOLD; when it reaches MIN_HOLD, go to OPEN. Higher-priority requests are ignored in this state.
  - OPEN: if a higher-priority req is set, switch grant to it, clear the hold counter and go to LOCKED. Otherwise keep the current owner.
  - Any state with an owner: if the owner's req is low, release the LED. If other reqs are set, grant the highest of them in the same boundary and go to LOCKED; otherwise set grant=0 and go to IDLE.
- The grant change and the new active duties take effect in the same cycle, so the first full period after a switch uses the new colour.
- busy = (state != IDLE), registered together with grant.
- Owner dropping and a higher-priority request arriving at the same boundary: the highest set req wins, same rule as above.
- An owner's req pulse shorter than one period is never seen, because only the level at the boundary matters.
- Reset mid-period forces the outputs low immediately. Counting restarts from 0 after reset is released.

Decomposition:
- Package rgb_led_pkg holds:
  - the FSM state enum (IDLE, LOCKED, OPEN);
  - colour index constants (RED=0, GREEN=1, BLUE=2);
  - default parameter constants.
- Sub-module rgb_pwm_channel: latched duty register plus compare and output flop. It is instantiated 3 times, sharing the counter and boundary strobe.

Test Plan:
1. Reset release, no req for 3 periods: grant=0, busy=0, all PWM outputs 0; period_start pulses every 1024 cycles.
2. req[1]=1 with duty_r=64, duty_g=0, duty_b=255: grant=2'b10 at the first boundary. From the next period, pwm_red is high for 256 clocks and pwm_blue for 1020 clocks of every 1024; pwm_green stays 0.
3. req[1] owner, req[0] raised after 3 periods: grant stays 2'b10 until 16 periods after the grant, then switches to 2'b01 exactly at a boundary. The new colour starts in the same cycle.
4. req[0] owner drops req with req[1]=1 pending while LOCKED: at the next boundary grant=2'b10, the hold counter restarts, and no idle period is inserted.
5. Duty change mid-period (duty_r 64->200 at counter 100): the current period still ends pwm_red at tick 64; the next period uses 200.
6. Assert rst mid-period while granted: all outputs go to 0 asynchronously. After release, grant is re-issued at the first boundary, 1024 cycles later.

Source files
------------

// File: rtl/rgb_led_pkg.sv
// Shared types and constants for the RGB LED arbiter: FSM state encoding,
// colour channel indices and the default parameter values.
package rgb_led_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOCKED = 2'd1,
      OPEN   = 2'd2
   } arb_state_t;

   localparam int RED   = 0;
   localparam int GREEN = 1;
   localparam int BLUE  = 2;

   localparam int DEF_NUM_REQ  = 2;
   localparam int DEF_PWM_BITS = 8;
   localparam int DEF_PRESCALE = 4;
   localparam int DEF_MIN_HOLD = 16;

endpackage

// File: rtl/rgb_pwm_channel.sv
// One PWM colour channel: holds the active duty latched at period boundaries
// and drives a registered compare of the shared counter against it.
module rgb_pwm_channel #(
   parameter int PWM_BITS = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                boundary,
   input  logic [PWM_BITS-1:0] cnt,
   input  logic [PWM_BITS-1:0] duty_next,
   output logic                pwm
);

   logic [PWM_BITS-1:0] duty_p0;

   // Active duty only changes at a period boundary, so a period is never cut short.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         duty_p0 <= '0;
      end else if (boundary) begin
         duty_p0 <= duty_next;
      end
   end

   // Registered compare keeps the output glitch-free; it lags the counter by one cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pwm <= 1'b0;
      end else begin
         pwm <= (cnt < duty_p0);
      end
   end

endmodule

// File: rtl/rgb_led_arbiter.sv
// Shares one RGB LED driver between NUM_REQ requesters. A fixed-priority
// arbiter with minimum ownership picks the owner at PWM period boundaries,
// and three PWM channels render the owner's colour.
module rgb_led_arbiter
   import rgb_led_pkg::*;
#(
   parameter int NUM_REQ  = DEF_NUM_REQ,
   parameter int PWM_BITS = DEF_PWM_BITS,
   parameter int PRESCALE = DEF_PRESCALE,
   parameter int MIN_HOLD = DEF_MIN_HOLD
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_REQ-1:0]           req,
   input  logic [NUM_REQ*PWM_BITS-1:0]  duty_r,
   input  logic [NUM_REQ*PWM_BITS-1:0]  duty_g,
   input  logic [NUM_REQ*PWM_BITS-1:0]  duty_b,
   output logic [NUM_REQ-1:0]           grant,
   output logic                         busy,
   output logic                         period_start,
   output logic                         pwm_red,
   output logic                         pwm_green,
   output logic                         pwm_blue
);

   localparam int PS_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int HOLD_W = $clog2(MIN_HOLD + 1);

   logic [PS_W-1:0]             presc;
   logic                        tick;
   logic [PWM_BITS-1:0]         cnt;
   logic                        boundary;

   arb_state_t                  state, state_n;
   logic [NUM_REQ-1:0]          grant_n;
   logic [HOLD_W-1:0]           hold, hold_n, hold_inc;
   logic [NUM_REQ-1:0]          pick;
   logic                        pick_found;
   logic                        owner_req;

   logic [NUM_REQ*PWM_BITS-1:0] duty_in [3];
   logic [PWM_BITS-1:0]         duty_sel [3];
   logic [2:0]                  pwm_out;

   assign tick     = (presc == PS_W'(PRESCALE - 1));
   assign boundary = tick && (cnt == '1);

   // Prescaler divides the clock down to one PWM counter tick every PRESCALE cycles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc <= '0;
      end else if (tick) begin
         presc <= '0;
      end else begin
         presc <= presc + 1'b1;
      end
   end

   // Free-running PWM counter; wraps naturally at its maximum value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt          <= '0;
         period_start <= 1'b0;
      end else begin
         if (tick) begin
            cnt <= cnt + 1'b1;
         end
         period_start <= boundary;
      end
   end

   // Lowest set request index is the highest-priority candidate.
   always_comb begin
      pick       = '0;
      pick_found = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (req[i] && !pick_found) begin
            pick[i]    = 1'b1;
            pick_found = 1'b1;
         end
      end
   end

   assign owner_req = |(req & grant);
   assign hold_inc  = (hold == HOLD_W'(MIN_HOLD)) ? hold : hold + 1'b1;

   // Arbitration next state: every decision is taken only at a period boundary.
   always_comb begin
      state_n = state;
      grant_n = grant;
      hold_n  = hold;
      if (boundary) begin
         case (state)
            IDLE: begin
               if (pick_found) begin
                  grant_n = pick;
                  hold_n  = '0;
                  state_n = LOCKED;
               end
            end
            LOCKED, OPEN: begin
               if (!owner_req) begin
                  // Owner released: hand over directly, no idle period in between.
                  hold_n = '0;
                  if (pick_found) begin
                     grant_n = pick;
                     state_n = LOCKED;
                  end else begin
                     grant_n = '0;
                     state_n = IDLE;
                  end
               end else if (state == OPEN || hold_inc == HOLD_W'(MIN_HOLD)) begin
                  // Minimum ownership is served once the hold reaches MIN_HOLD,
                  // so a waiting higher-priority requester takes over right here.
                  if (pick != grant) begin
                     grant_n = pick;
                     hold_n  = '0;
                     state_n = LOCKED;
                  end else begin
                     hold_n  = hold_inc;
                     state_n = OPEN;
                  end
               end else begin
                  hold_n = hold_inc;
               end
            end
            default: begin
               grant_n = '0;
               hold_n  = '0;
               state_n = IDLE;
            end
         endcase
      end
   end

   // Arbitration state; grant and busy are registered together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         grant <= '0;
         hold  <= '0;
         busy  <= 1'b0;
      end else begin
         state <= state_n;
         grant <= grant_n;
         hold  <= hold_n;
         busy  <= (state_n != IDLE);
      end
   end

   assign duty_in[RED]   = duty_r;
   assign duty_in[GREEN] = duty_g;
   assign duty_in[BLUE]  = duty_b;

   // Duty of the next owner per channel; zero when nobody will own the LED.
   always_comb begin
      for (int c = 0; c < 3; c++) begin
         duty_sel[c] = '0;
         for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_n[i]) begin
               duty_sel[c] = duty_in[c][i*PWM_BITS +: PWM_BITS];
            end
         end
      end
   end

   for (genvar c = 0; c < 3; c++) begin : g_ch
      rgb_pwm_channel #(
         .PWM_BITS (PWM_BITS)
      ) u_ch (
         .clk       (clk),
         .rst       (rst),
         .boundary  (boundary),
         .cnt       (cnt),
         .duty_next (duty_sel[c]),
         .pwm       (pwm_out[c])
      );
   end

   assign pwm_red   = pwm_out[RED];
   assign pwm_green = pwm_out[GREEN];
   assign pwm_blue  = pwm_out[BLUE];

endmodule

// File: tb/tb_rgb_led_arbiter.sv
// Bench for rgb_led_arbiter with default parameters: a table of per-period
// vectors plus directed sequences for preemption, mid-period duty change
// and mid-period reset.
module tb_rgb_led_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [1:0]  req = '0;
   logic [15:0] duty_r = '0;
   logic [15:0] duty_g = '0;
   logic [15:0] duty_b = '0;
   logic [1:0]  grant;
   logic        busy;
   logic        period_start;
   logic        pwm_red;
   logic        pwm_green;
   logic        pwm_blue;

   int checks = 0;
   int errors = 0;
   int cyc;

   rgb_led_arbiter dut (
      .clk          (clk),
      .rst          (rst),
      .req          (req),
      .duty_r       (duty_r),
      .duty_g       (duty_g),
      .duty_b       (duty_b),
      .grant        (grant),
      .busy         (busy),
      .period_start (period_start),
      .pwm_red      (pwm_red),
      .pwm_green    (pwm_green),
      .pwm_blue     (pwm_blue)
   );

   always #5 clk = ~clk;

   // Bench-side cycle count since reset release; boundaries fall on multiples of 1024.
   always @(posedge clk or posedge rst) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [1:0]  req;
      logic [15:0] dr, dg, db;
      logic [1:0]  g;
      logic        busy;
      int          hr, hg, hb;
   } vec_t;

   vec_t vt [7];

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic next_boundary();
      for (int i = 0; i < 2048; i++) begin
         @(posedge clk); #1;
         if (cyc % 1024 == 0) break;
      end
   endtask

   task automatic to_pre_boundary();
      for (int i = 0; i < 2048; i++) begin
         @(posedge clk); #1;
         if (cyc % 1024 == 1023) break;
      end
   endtask

   // Starts just after a boundary edge, ends one edge before the next boundary.
   task automatic measure(output int hr, output int hg, output int hb,
                          output int ps, output int ps0);
      hr = 0; hg = 0; hb = 0; ps = 0;
      ps0 = int'(period_start);
      for (int k = 0; k < 1024; k++) begin
         if (k > 0) begin @(posedge clk); #1; end
         hr += int'(pwm_red);
         hg += int'(pwm_green);
         hb += int'(pwm_blue);
         ps += int'(period_start);
      end
   endtask

   initial begin
      int hr, hg, hb, ps, ps0;

      vt[0] = '{req:2'b10, dr:{8'd64,8'd9},  dg:{8'd0,8'd9},   db:{8'd255,8'd9}, g:2'b10, busy:1'b1, hr:256,  hg:0,   hb:1020};
      vt[1] = '{req:2'b10, dr:{8'd10,8'd77}, dg:{8'd20,8'd77}, db:{8'd30,8'd77}, g:2'b10, busy:1'b1, hr:40,   hg:80,  hb:120};
      vt[2] = '{req:2'b00, dr:{8'd10,8'd77}, dg:{8'd20,8'd77}, db:{8'd30,8'd77}, g:2'b00, busy:1'b0, hr:0,    hg:0,   hb:0};
      vt[3] = '{req:2'b01, dr:{8'd5,8'd255}, dg:{8'd6,8'd128}, db:{8'd7,8'd1},   g:2'b01, busy:1'b1, hr:1020, hg:512, hb:4};
      vt[4] = '{req:2'b11, dr:{8'd5,8'd255}, dg:{8'd6,8'd128}, db:{8'd7,8'd1},   g:2'b01, busy:1'b1, hr:1020, hg:512, hb:4};
      vt[5] = '{req:2'b10, dr:{8'd5,8'd255}, dg:{8'd6,8'd128}, db:{8'd7,8'd1},   g:2'b10, busy:1'b1, hr:20,   hg:24,  hb:28};
      vt[6] = '{req:2'b00, dr:{8'd5,8'd255}, dg:{8'd6,8'd128}, db:{8'd7,8'd1},   g:2'b00, busy:1'b0, hr:0,    hg:0,   hb:0};

      // Reset state
      #1 rst = 1'b1;
      #2;
      chk("rst_grant", grant, 0);
      chk("rst_busy", busy, 0);
      chk("rst_period_start", period_start, 0);
      chk("rst_pwm", {pwm_red, pwm_green, pwm_blue}, 0);
      @(posedge clk); @(posedge clk); #2 rst = 1'b0;

      // Idle for three periods
      to_pre_boundary();
      chk("idle_pre_ps", period_start, 0);
      for (int p = 0; p < 3; p++) begin
         next_boundary();
         chk("idle_grant", grant, 0);
         chk("idle_busy", busy, 0);
         measure(hr, hg, hb, ps, ps0);
         chk("idle_ps_first", ps0, 1);
         chk("idle_ps_count", ps, 1);
         chk("idle_pwm", hr + hg + hb, 0);
      end

      // Table of per-period vectors
      for (int v = 0; v < 7; v++) begin
         req = vt[v].req; duty_r = vt[v].dr; duty_g = vt[v].dg; duty_b = vt[v].db;
         next_boundary();
         chk($sformatf("v%0d_grant", v), grant, vt[v].g);
         chk($sformatf("v%0d_busy", v), busy, vt[v].busy);
         measure(hr, hg, hb, ps, ps0);
         chk($sformatf("v%0d_red", v), hr, vt[v].hr);
         chk($sformatf("v%0d_green", v), hg, vt[v].hg);
         chk($sformatf("v%0d_blue", v), hb, vt[v].hb);
      end

      // Preemption after minimum hold
      req = 2'b10;
      duty_r = {8'd64, 8'd200}; duty_g = {8'd0, 8'd100}; duty_b = {8'd255, 8'd50};
      next_boundary();
      chk("pre_grant_b0", grant, 2);
      for (int p = 1; p <= 16; p++) begin
         if (p == 4) req = 2'b11;
         next_boundary();
         if (p < 16) chk($sformatf("pre_hold_b%0d", p), grant, 2);
         else        chk("pre_switch_b16", grant, 1);
      end
      chk("pre_busy", busy, 1);
      measure(hr, hg, hb, ps, ps0);
      chk("pre_red", hr, 800);
      chk("pre_green", hg, 400);
      chk("pre_blue", hb, 200);

      // Duty change mid-period
      duty_r[7:0] = 8'd64;
      next_boundary();
      hr = 0;
      for (int k = 0; k < 1024; k++) begin
         if (k > 0) begin @(posedge clk); #1; end
         if (k == 400) duty_r[7:0] = 8'd200;
         if (k == 256) chk("mid_red_last_high", pwm_red, 1);
         if (k == 257) chk("mid_red_fall", pwm_red, 0);
         hr += int'(pwm_red);
      end
      chk("mid_red_count", hr, 256);
      next_boundary();
      measure(hr, hg, hb, ps, ps0);
      chk("mid_red_next", hr, 800);

      // Reset mid-period while granted
      req = 2'b01;
      next_boundary();
      for (int k = 0; k < 20; k++) begin @(posedge clk); #1; end
      chk("rst_mid_red_before", pwm_red, 1);
      rst = 1'b1;
      #1;
      chk("rst_mid_grant", grant, 0);
      chk("rst_mid_busy", busy, 0);
      chk("rst_mid_red", pwm_red, 0);
      chk("rst_mid_blue", pwm_blue, 0);
      @(posedge clk); @(posedge clk); #2 rst = 1'b0;
      to_pre_boundary();
      chk("rst_rel_grant_pre", grant, 0);
      next_boundary();
      chk("rst_rel_grant", grant, 1);
      chk("rst_rel_busy", busy, 1);
      chk("rst_rel_ps", period_start, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
